// File: rtl/intr_sequencer_if.sv
// Interrupt sequencer bundle between the core control path and the sequencer.
// The master side is the sequencer. The slave side is the core, memory and stack.
interface intr_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              intr;
  logic              imm_pending;
  logic              br_taken;
  logic [DATA_W-1:0] br_target;
  logic              rti_retire;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] mem_rdata;
  logic              pc_stall;
  logic              inject_bubble;
  logic              ifid_flush;
  logic              push_en;
  logic [DATA_W-1:0] push_data;
  logic              vec_rd_en;
  logic [DATA_W-1:0] vec_addr;
  logic              pc_load;
  logic [DATA_W-1:0] pc_load_val;
  logic              intr_ack;
  logic              in_isr;

  modport master (
    input  intr, imm_pending, br_taken, br_target,
    input  rti_retire, pc_in, mem_rdata,
    output pc_stall, inject_bubble, ifid_flush,
    output push_en, push_data, vec_rd_en, vec_addr,
    output pc_load, pc_load_val, intr_ack, in_isr
  );

  modport slave (
    output intr, imm_pending, br_taken, br_target,
    output rti_retire, pc_in, mem_rdata,
    input  pc_stall, inject_bubble, ifid_flush,
    input  push_en, push_data, vec_rd_en, vec_addr,
    input  pc_load, pc_load_val, intr_ack, in_isr
  );
endinterface

// File: rtl/intr_sequencer.sv
// Interrupt entry/exit sequencer: drains the pipe, pushes the return PC,
// reads the ISR vector, redirects fetch and blocks nesting until RTI.
module intr_sequencer #(
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] VEC_ADDR     = 'h01,
  parameter int                DRAIN_CYCLES = 3,
  parameter int                SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  intr_sequencer_if.master bus
);
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, DRAIN, PUSH, VEC_RD, VEC_LD, ISR
  } state_t;

  state_t            st, nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              sync_prev;
  logic              intr_edge;
  logic              pending;
  logic [DATA_W-1:0] save_pc;
  logic [CNT_W-1:0]  cnt;
  logic              enter;

  assign intr_edge = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign enter     = (st == IDLE) && (nxt == DRAIN);
  assign bus.vec_addr = VEC_ADDR;

  // State register; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= nxt;
  end

  // Synchroniser, edge latch, return PC capture and drain counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      pending   <= 1'b0;
      save_pc   <= '0;
      cnt       <= '0;
    end else begin
      sync_q    <= SYNC_STAGES'({sync_q, bus.intr});
      sync_prev <= sync_q[SYNC_STAGES-1];
      if (st == PUSH)     pending <= 1'b0;
      else if (intr_edge) pending <= 1'b1;
      if (enter) begin
        save_pc <= bus.pc_in;
        cnt     <= CNT_INIT;
      end else if (st == DRAIN) begin
        if (bus.br_taken) save_pc <= bus.br_target;
        if (cnt != '0)    cnt <= cnt - 1'b1;
      end
    end
  end

  // Next-state decode
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:
        if (pending && !bus.imm_pending && !bus.br_taken)
          nxt = DRAIN;
      DRAIN:  if (cnt == '0) nxt = PUSH;
      PUSH:   nxt = VEC_RD;
      VEC_RD: nxt = VEC_LD;
      VEC_LD: nxt = ISR;
      ISR:    if (bus.rti_retire) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Per-state control outputs; data buses are zero unless strobed
  always_comb begin
    bus.pc_stall      = 1'b0;
    bus.inject_bubble = 1'b0;
    bus.ifid_flush    = 1'b0;
    bus.push_en       = 1'b0;
    bus.push_data     = '0;
    bus.vec_rd_en     = 1'b0;
    bus.pc_load       = 1'b0;
    bus.pc_load_val   = '0;
    bus.intr_ack      = 1'b0;
    bus.in_isr        = 1'b0;
    unique case (st)
      DRAIN: begin
        bus.pc_stall      = 1'b1;
        bus.inject_bubble = 1'b1;
      end
      PUSH: begin
        bus.pc_stall      = 1'b1;
        bus.inject_bubble = 1'b1;
        bus.push_en       = 1'b1;
        bus.push_data     = save_pc;
        bus.intr_ack      = 1'b1;
      end
      VEC_RD: begin
        bus.pc_stall      = 1'b1;
        bus.inject_bubble = 1'b1;
        bus.vec_rd_en     = 1'b1;
      end
      VEC_LD: begin
        bus.pc_load       = 1'b1;
        bus.pc_load_val   = bus.mem_rdata;
        bus.ifid_flush    = 1'b1;
        bus.inject_bubble = 1'b1;
      end
      ISR:     bus.in_isr = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_intr_sequencer.sv
// Directed bench for intr_sequencer: entry timing, guards, branch capture,
// nesting block, mid-sequence reset and synchroniser behaviour.
module tb_intr_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  intr_sequencer_if #(.DATA_W(8)) bus();

  intr_sequencer #(
    .DATA_W(8), .VEC_ADDR(8'h01),
    .DRAIN_CYCLES(3), .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;
  int load_cnt = 0;
  int a0, l0;
  logic [7:0] mem [256];

  // data memory: read data valid the cycle after vec_rd_en
  always @(posedge clk)
    bus.mem_rdata <= bus.vec_rd_en ? mem[bus.vec_addr] : 8'h00;

  // strobe counters sampled mid-cycle
  always @(negedge clk) begin
    if (bus.intr_ack === 1'b1) ack_cnt++;
    if (bus.pc_load === 1'b1)  load_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one-cycle clk-aligned pulse, then wait until pending has latched
  task automatic pulse();
    bus.intr = 1'b1;
    step();
    bus.intr = 1'b0;
    step();
    step();
  endtask

  // from IDLE with pending set: full entry sequence up to ISR
  task automatic seq(input logic [7:0] exp_push, input int br_at);
    step();
    chk("drain_ack", 32'(bus.intr_ack), 0);
    chk("drain_pdata", 32'(bus.push_data), 0);
    for (int i = 1; i <= 3; i++) begin
      chk("drain_stall", 32'(bus.pc_stall & bus.inject_bubble), 1);
      if (i == br_at) begin
        bus.br_taken  = 1'b1;
        bus.br_target = 8'h44;
      end
      step();
      bus.br_taken  = 1'b0;
      bus.br_target = 8'h00;
    end
    chk("push_en", 32'(bus.push_en), 1);
    chk("push_ack", 32'(bus.intr_ack), 1);
    chk("push_data", 32'(bus.push_data), 32'(exp_push));
    chk("push_stall", 32'(bus.pc_stall), 1);
    step();
    chk("vrd_en", 32'(bus.vec_rd_en), 1);
    chk("vrd_addr", 32'(bus.vec_addr), 1);
    chk("vrd_ldval", 32'(bus.pc_load_val), 0);
    step();
    chk("vld_load", 32'(bus.pc_load), 1);
    chk("vld_val", 32'(bus.pc_load_val), 32'h80);
    chk("vld_flush", 32'(bus.ifid_flush), 1);
    chk("vld_stall", 32'(bus.pc_stall), 0);
    step();
    chk("isr_in", 32'(bus.in_isr), 1);
    chk("isr_stall", 32'(bus.pc_stall), 0);
  endtask

  task automatic rti();
    bus.rti_retire = 1'b1;
    step();
    bus.rti_retire = 1'b0;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    mem[1] = 8'h80;
    rst             = 1'b0;
    bus.intr        = 1'b0;
    bus.imm_pending = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_target   = 8'h00;
    bus.rti_retire  = 1'b0;
    bus.pc_in       = 8'h20;
    step();
    step();
    chk("rst_stall", 32'(bus.pc_stall), 0);
    chk("rst_push", 32'(bus.push_en), 0);
    chk("rst_load", 32'(bus.pc_load), 0);
    chk("rst_isr", 32'(bus.in_isr), 0);
    chk("rst_vaddr", 32'(bus.vec_addr), 1);
    rst = 1'b1;
    step();

    // basic entry
    pulse();
    chk("pend_idle", 32'(bus.pc_stall), 0);
    seq(8'h20, 0);

    // nesting block and absorbed third edge
    pulse();
    chk("nest_stall", 32'(bus.pc_stall), 0);
    chk("nest_ack", 32'(bus.intr_ack), 0);
    chk("nest_isr", 32'(bus.in_isr), 1);
    a0 = ack_cnt;
    pulse();
    step();
    step();
    chk("nest_nack", 32'(ack_cnt - a0), 0);
    bus.pc_in = 8'h30;
    rti();
    chk("rti_drop", 32'(bus.in_isr), 0);
    seq(8'h30, 0);
    rti();
    repeat (8) step();
    chk("single_ack", 32'(ack_cnt - a0), 1);
    chk("no_reentry", 32'(bus.pc_stall), 0);

    // two-byte instruction guard
    bus.pc_in       = 8'h50;
    bus.imm_pending = 1'b1;
    pulse();
    for (int i = 0; i < 3; i++) begin
      chk("imm_hold", 32'(bus.pc_stall), 0);
      step();
    end
    bus.imm_pending = 1'b0;
    bus.pc_in       = 8'h57;
    seq(8'h57, 0);
    rti();

    // branch in second drain cycle wins the return address
    bus.pc_in = 8'h60;
    pulse();
    seq(8'h44, 2);
    rti();

    // rti outside ISR is ignored
    rti();
    chk("rti_idle_isr", 32'(bus.in_isr), 0);
    chk("rti_idle_stall", 32'(bus.pc_stall), 0);

    // reset during VEC_RD
    pulse();
    repeat (5) step();
    chk("pre_rst_vrd", 32'(bus.vec_rd_en), 1);
    l0 = load_cnt;
    a0 = ack_cnt;
    #2 rst = 1'b0;
    #1;
    chk("arst_vrd", 32'(bus.vec_rd_en), 0);
    chk("arst_stall", 32'(bus.pc_stall), 0);
    chk("arst_bubble", 32'(bus.inject_bubble), 0);
    step();
    chk("arst_load", 32'(bus.pc_load), 0);
    step();
    rst = 1'b1;
    repeat (8) step();
    chk("rst_noload", 32'(load_cnt - l0), 0);
    chk("rst_idle", 32'(bus.pc_stall), 0);

    // reset during DRAIN drops the pending request
    pulse();
    step();
    chk("pre_rst_drain", 32'(bus.pc_stall), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_drain", 32'(bus.pc_stall), 0);
    step();
    rst = 1'b1;
    repeat (8) step();
    chk("rst_pend_clr", 32'(ack_cnt - a0), 0);
    chk("rst_pend_stall", 32'(bus.pc_stall), 0);

    // intr held high for 10 cycles gives one ack
    a0 = ack_cnt;
    bus.intr = 1'b1;
    repeat (10) step();
    bus.intr = 1'b0;
    repeat (5) step();
    chk("hold_ack", 32'(ack_cnt - a0), 1);
    chk("hold_isr", 32'(bus.in_isr), 1);

    // edge detected in the same cycle as rti_retire
    bus.pc_in = 8'h70;
    bus.intr  = 1'b1;
    step();
    bus.intr  = 1'b0;
    step();
    bus.rti_retire = 1'b1;
    step();
    bus.rti_retire = 1'b0;
    chk("edge_rti_isr", 32'(bus.in_isr), 0);
    seq(8'h70, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/intr_sequencer.md
Name: intr_sequencer

Overview:
Interrupt entry/exit sequencer for the 5-stage pipelined 8-bit core. It sits beside the main control unit and takes over fetch control when INTR is recognised. It drains the pipeline at a clean instruction boundary, pushes the return PC, fetches the ISR vector from data memory and redirects the PC. It blocks nested interrupts until RTI retires.

Parameters:
DATA_W, 8, datapath/PC width
VEC_ADDR, 8'h01, data-memory address holding the ISR start address
DRAIN_CYCLES, 3, cycles of bubbles needed to retire in-flight instructions (ID/EX/MEM)
SYNC_STAGES, 2, synchroniser flops on intr

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
intr  in  1  external interrupt request, asynchronous, rising-edge sensitive
imm_pending  in  1  control unit is mid two-byte instruction (FETCH_IMM); interrupt must not split it
br_taken  in  1  taken branch/JMP/CALL/RET redirect resolved this cycle
br_target  in  DATA_W  redirect target when br_taken=1
rti_retire  in  1  one-cycle pulse when RTI completes in MEM
pc_in  in  DATA_W  PC of next instruction to be fetched
mem_rdata  in  DATA_W  data-memory read data (valid cycle after vec_rd_en)
pc_stall  out  1  hold PC and IF/ID
inject_bubble  out  1  force NOP into ID/EX
ifid_flush  out  1  clear IF/ID
push_en  out  1  one-cycle stack push request (SP decrement + write)
push_data  out  DATA_W  value to push (saved PC)
vec_rd_en  out  1  data-memory read request
vec_addr  out  DATA_W  constant VEC_ADDR
pc_load  out  1  load PC with pc_load_val
pc_load_val  out  DATA_W  ISR start address
intr_ack  out  1  one-cycle pulse, interrupt accepted
in_isr  out  1  ISR active, nesting blocked

Behaviour:
- Reset: state IDLE; pending, save_pc, drain counter, sync flops all 0; every output 0 except vec_addr=VEC_ADDR. Reset mid-sequence aborts immediately to IDLE with no partial push.
- Input path: intr passes through SYNC_STAGES flops, then an edge detector (sync_out & ~sync_prev). A detected edge sets the pending register. Pending is cleared only on PUSH entry. An edge arriving while pending=1 is absorbed; no counting.
- States: IDLE, DRAIN, PUSH, VEC_RD, VEC_LD, ISR.
- IDLE: all control outputs 0.
  - Go to DRAIN when pending & ~imm_pending & ~br_taken.
  - On the transition edge: save_pc<=pc_in, counter<=DRAIN_CYCLES-1.
- DRAIN: pc_stall=1, inject_bubble=1.
  - If br_taken, save_pc<=br_target, because a branch in flight wins the return address.
  - Counter decrements each cycle; go to PUSH when counter==0. Duration is exactly DRAIN_CYCLES cycles.
- PUSH (1 cycle): pc_stall=1, inject_bubble=1, push_en=1, push_data=save_pc, intr_ack=1; pending<=0.
- VEC_RD (1 cycle): pc_stall=1, inject_bubble=1, vec_rd_en=1.
- VEC_LD (1 cycle): pc_load=1, pc_load_val=mem_rdata, ifid_flush=1, inject_bubble=1; pc_stall=0.
- ISR: in_isr=1, no stall.
  - New edges set pending but are not serviced.
  - rti_retire -> IDLE; in_isr drops the following cycle.
- Fixed latency from pending set to pc_load = 1 + DRAIN_CYCLES + 2 cycles, i.e. 6 with defaults, unless IDLE is held by imm_pending/br_taken.
- Simultaneous events:
  - Edge and rti_retire in the same cycle: pending set, go to IDLE, enter DRAIN the next cycle.
  - Edge while imm_pending: wait in IDLE until imm_pending=0.
  - rti_retire outside ISR: ignored.
- push_data and pc_load_val are 0 whenever their strobe is 0.

Test Plan:
- Basic entry: rst release, pc_in=8'h20, M[1]=8'h80, pulse intr.
  - Expect intr_ack and push_en with push_data=8'h20 exactly 4 cycles after pending sets.
  - Expect pc_load, pc_load_val=8'h80 and ifid_flush 2 cycles later.
  - Then in_isr=1.
- Two-byte guard: raise intr while imm_pending=1 for 3 cycles.
  - Stays IDLE (pc_stall=0) until imm_pending falls, then DRAIN.
  - save_pc equals pc_in at the exit cycle.
- Branch during drain: br_taken=1, br_target=8'h44 in the 2nd DRAIN cycle.
  - push_data=8'h44, not the captured pc_in.
- Nesting block: second intr edge during ISR gives no stall and no ack.
  - After rti_retire: re-entry with intr_ack one full sequence later.
  - A third edge while already pending still yields a single ack.
- Reset mid-sequence: assert rst during VEC_RD.
  - All outputs 0 asynchronously, no pc_load, state IDLE, pending=0 after release.
- Synchroniser: 1-cycle intr glitch aligned to clk is recognised once.
  - intr held high 10 cycles produces exactly one intr_ack.
